// File: rtl/imm_gen_pipe_if.sv
// Valid/ready bus around the immediate generator: instruction in, immediate/format out.
// out_illegal exists only when IMMGEN_ILLEGAL_EN is defined.
interface imm_gen_pipe_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [31:0]     in_instr;
  logic            out_valid;
  logic            out_ready;
  logic [XLEN-1:0] out_imm;
  logic [2:0]      out_type;
`ifdef IMMGEN_ILLEGAL_EN
  logic            out_illegal;
`endif

  modport slave (
    input  in_valid, in_instr, out_ready,
`ifdef IMMGEN_ILLEGAL_EN
    output out_illegal,
`endif
    output in_ready, out_valid, out_imm, out_type
  );

  modport master (
    output in_valid, in_instr, out_ready,
`ifdef IMMGEN_ILLEGAL_EN
    input  out_illegal,
`endif
    input  in_ready, out_valid, out_imm, out_type
  );
endinterface

// File: rtl/imm_gen_pipe.sv
// Pipelined RISC-V I/S/B/U/J immediate generator with elastic valid/ready stages.
// Optional illegal-encoding flag: define IMMGEN_ILLEGAL_EN.
module imm_gen_pipe #(
  parameter int XLEN   = 32,
  parameter int STAGES = 1
) (
  input  logic           clk,
  input  logic           rst_n,
  imm_gen_pipe_if.slave  bus
);

  localparam logic [2:0] T_NONE = 3'd0;
  localparam logic [2:0] T_I    = 3'd1;
  localparam logic [2:0] T_S    = 3'd2;
  localparam logic [2:0] T_B    = 3'd3;
  localparam logic [2:0] T_U    = 3'd4;
  localparam logic [2:0] T_J    = 3'd5;

  function automatic logic [XLEN-1:0] sext32(input logic signed [31:0] v);
    return XLEN'(v);
  endfunction

  logic [31:0]     w_instr;
  logic [6:0]      w_op;
  logic [XLEN-1:0] w_imm_p0;
  logic [2:0]      w_type_p0;
`ifdef IMMGEN_ILLEGAL_EN
  logic            w_known;
  logic            w_ill_p0;
`endif

  assign w_instr = bus.in_instr;
  assign w_op    = w_instr[6:0];

  always_comb begin
    w_imm_p0  = '0;
    w_type_p0 = T_NONE;
`ifdef IMMGEN_ILLEGAL_EN
    w_known   = 1'b1;
`endif
    case (w_op)
      7'b0010011, 7'b0000011, 7'b1100111: begin
        w_type_p0 = T_I;
        w_imm_p0  = sext32({{20{w_instr[31]}}, w_instr[31:20]});
      end
      7'b0011011: begin
        if (XLEN == 64) begin
          w_type_p0 = T_I;
          w_imm_p0  = sext32({{20{w_instr[31]}}, w_instr[31:20]});
        end
`ifdef IMMGEN_ILLEGAL_EN
        else begin
          w_known = 1'b0;
        end
`endif
      end
      7'b0100011: begin
        w_type_p0 = T_S;
        w_imm_p0  = sext32({{20{w_instr[31]}}, w_instr[31:25], w_instr[11:7]});
      end
      7'b1100011: begin
        w_type_p0 = T_B;
        w_imm_p0  = sext32({{19{w_instr[31]}}, w_instr[31], w_instr[7],
                            w_instr[30:25], w_instr[11:8], 1'b0});
      end
      7'b0110111, 7'b0010111: begin
        w_type_p0 = T_U;
        w_imm_p0  = sext32({w_instr[31:12], 12'b0});
      end
      7'b1101111: begin
        w_type_p0 = T_J;
        w_imm_p0  = sext32({{11{w_instr[31]}}, w_instr[31], w_instr[19:12],
                            w_instr[20], w_instr[30:21], 1'b0});
      end
`ifdef IMMGEN_ILLEGAL_EN
      // Recognised opcodes that simply carry no immediate.
      7'b0110011, 7'b0111011, 7'b0001111, 7'b1110011: begin
        w_known = 1'b1;
      end
`endif
      default: begin
`ifdef IMMGEN_ILLEGAL_EN
        w_known = 1'b0;
`endif
      end
    endcase
  end

`ifdef IMMGEN_ILLEGAL_EN
  // Unknown opcodes already decode to imm 0 / NONE, so only the flag is added.
  assign w_ill_p0 = !w_known || (w_instr[1:0] != 2'b11);
`endif

  logic [STAGES-1:0] r_vld_p;
  logic [XLEN-1:0]   r_imm_p  [STAGES];
  logic [2:0]        r_type_p [STAGES];
`ifdef IMMGEN_ILLEGAL_EN
  logic [STAGES-1:0] r_ill_p;
`endif
  logic [STAGES:0]   w_rdy;

  // Stage k may load if the consumer is ready or any stage from k onward is empty.
  assign w_rdy[STAGES] = bus.out_ready;
  for (genvar k = 0; k < STAGES; k++) begin : g_rdy
    assign w_rdy[k] = bus.out_ready | ~(&r_vld_p[STAGES-1:k]);
  end

  // ---- stage boundary: decode -> p[0] -> ... -> p[STAGES-1] ----
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vld_p <= '0;
`ifdef IMMGEN_ILLEGAL_EN
      r_ill_p <= '0;
`endif
      for (int k = 0; k < STAGES; k++) begin
        r_imm_p[k]  <= '0;
        r_type_p[k] <= T_NONE;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (w_rdy[k]) begin
          if (k == 0) begin
            r_vld_p[k]  <= bus.in_valid;
            r_imm_p[k]  <= w_imm_p0;
            r_type_p[k] <= w_type_p0;
`ifdef IMMGEN_ILLEGAL_EN
            r_ill_p[k]  <= w_ill_p0;
`endif
          end else begin
            r_vld_p[k]  <= r_vld_p[k-1];
            r_imm_p[k]  <= r_imm_p[k-1];
            r_type_p[k] <= r_type_p[k-1];
`ifdef IMMGEN_ILLEGAL_EN
            r_ill_p[k]  <= r_ill_p[k-1];
`endif
          end
        end
      end
    end
  end

  assign bus.in_ready  = w_rdy[0];
  assign bus.out_valid = r_vld_p[STAGES-1];
  assign bus.out_imm   = r_imm_p[STAGES-1];
  assign bus.out_type  = r_type_p[STAGES-1];
`ifdef IMMGEN_ILLEGAL_EN
  assign bus.out_illegal = r_ill_p[STAGES-1];
`endif

endmodule

// File: tb/tb_imm_gen_pipe.sv
// Bench for imm_gen_pipe: three configurations driven from one directed sequence,
// outputs checked against a queue of expected items.
module tb_imm_gen_pipe;

  typedef struct {
    logic [63:0] imm;
    logic [2:0]  typ;
    logic        ill;
  } exp_t;

  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  exp_t        q [3][$];
  bit          held     [3];
  logic [63:0] held_imm [3];
  logic [2:0]  held_typ [3];

  // A: XLEN=32 STAGES=1, B: XLEN=64 STAGES=2, C: XLEN=32 STAGES=3
  imm_gen_pipe_if #(.XLEN(32)) ifa ();
  imm_gen_pipe_if #(.XLEN(64)) ifb ();
  imm_gen_pipe_if #(.XLEN(32)) ifc ();

  imm_gen_pipe #(.XLEN(32), .STAGES(1)) ua (.clk(clk), .rst_n(rst_n), .bus(ifa.slave));
  imm_gen_pipe #(.XLEN(64), .STAGES(2)) ub (.clk(clk), .rst_n(rst_n), .bus(ifb.slave));
  imm_gen_pipe #(.XLEN(32), .STAGES(3)) uc (.clk(clk), .rst_n(rst_n), .bus(ifc.slave));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    assert (got === exp) else begin
      bad++;
      $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic exp_t ref_dec(input logic [31:0] w, input bit x64);
    exp_t        e;
    logic [63:0] sx;
    bit          known;
    sx    = {64{w[31]}};
    e.imm = '0;
    e.typ = 3'd0;
    known = 1'b1;
    case (w[6:0])
      7'h13, 7'h03, 7'h67: begin e.typ = 3'd1; e.imm = {sx[63:12], w[31:20]}; end
      7'h1B: if (x64) begin e.typ = 3'd1; e.imm = {sx[63:12], w[31:20]}; end
             else known = 1'b0;
      7'h23: begin e.typ = 3'd2; e.imm = {sx[63:12], w[31:25], w[11:7]}; end
      7'h63: begin e.typ = 3'd3; e.imm = {sx[63:13], w[31], w[7], w[30:25], w[11:8], 1'b0}; end
      7'h37, 7'h17: begin e.typ = 3'd4; e.imm = {sx[63:32], w[31:12], 12'h000}; end
      7'h6F: begin e.typ = 3'd5; e.imm = {sx[63:21], w[31], w[19:12], w[20], w[30:21], 1'b0}; end
      7'h33, 7'h3B, 7'h0F, 7'h73: ;
      default: known = 1'b0;
    endcase
    e.ill = !known || (w[1:0] != 2'b11);
    if (!x64) e.imm = {32'h0, e.imm[31:0]};
    return e;
  endfunction

  // Pop/compare on an output transfer, push on an input transfer, watch held outputs.
  task automatic sb_one(input int d, input bit x64, input logic iv, input logic ir,
                        input logic [31:0] instr, input logic ov, input logic ordy,
                        input logic [63:0] imm, input logic [2:0] typ, input logic ill);
    exp_t e;
    if (ov && ordy) begin
      if (q[d].size() == 0) begin
        chk($sformatf("unexpected_out_%0d", d), 64'(ov), 64'd0);
      end else begin
        e = q[d].pop_front();
        chk($sformatf("imm_%0d", d), imm, e.imm);
        chk($sformatf("type_%0d", d), 64'(typ), 64'(e.typ));
`ifdef IMMGEN_ILLEGAL_EN
        chk($sformatf("ill_%0d", d), 64'(ill), 64'(e.ill));
`endif
      end
    end
    if (ov && !ordy) begin
      if (held[d]) begin
        chk($sformatf("hold_imm_%0d", d), imm, held_imm[d]);
        chk($sformatf("hold_type_%0d", d), 64'(typ), 64'(held_typ[d]));
      end
      held[d]     = 1'b1;
      held_imm[d] = imm;
      held_typ[d] = typ;
    end else begin
      held[d] = 1'b0;
    end
    if (iv && ir) q[d].push_back(ref_dec(instr, x64));
    if (^ill === 1'bx) held[d] = held[d];
  endtask

  task automatic half();
    logic la, lb, lc;
`ifdef IMMGEN_ILLEGAL_EN
    la = ifa.out_illegal; lb = ifb.out_illegal; lc = ifc.out_illegal;
`else
    la = 1'b0; lb = 1'b0; lc = 1'b0;
`endif
    @(negedge clk);
    sb_one(0, 1'b0, ifa.in_valid, ifa.in_ready, ifa.in_instr, ifa.out_valid, ifa.out_ready,
           {32'h0, ifa.out_imm}, ifa.out_type, la);
    sb_one(1, 1'b1, ifb.in_valid, ifb.in_ready, ifb.in_instr, ifb.out_valid, ifb.out_ready,
           ifb.out_imm, ifb.out_type, lb);
    sb_one(2, 1'b0, ifc.in_valid, ifc.in_ready, ifc.in_instr, ifc.out_valid, ifc.out_ready,
           {32'h0, ifc.out_imm}, ifc.out_type, lc);
  endtask

  task automatic rise();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_all();
    ifa.in_valid = 1'b0; ifb.in_valid = 1'b0; ifc.in_valid = 1'b0;
    ifa.out_ready = 1'b1; ifb.out_ready = 1'b1; ifc.out_ready = 1'b1;
  endtask

  task automatic drain(input string tag);
    idle_all();
    for (int i = 0; i < 12; i++) begin
      half();
      rise();
    end
    for (int d = 0; d < 3; d++)
      chk($sformatf("%s_empty_%0d", tag, d), 64'(q[d].size()), 64'd0);
  endtask

  function automatic logic [31:0] rand_word();
    logic [6:0]  ops [14];
    logic [31:0] r;
    ops = '{7'h13, 7'h03, 7'h67, 7'h1B, 7'h23, 7'h63, 7'h37, 7'h17, 7'h6F,
            7'h33, 7'h3B, 7'h0F, 7'h73, 7'h00};
    r = $urandom();
    if (r[3:0] == 4'hF) return r;
    return {r[31:7], ops[$urandom_range(0, 12)]};
  endfunction

  logic [31:0] t2_w   [4];
  logic [31:0] t2_imm [4];
  logic [2:0]  t2_typ [4];
  logic [31:0] t3_w   [6];

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b0;
    for (int d = 0; d < 3; d++) held[d] = 1'b0;
    ifa.in_instr = '0; ifb.in_instr = '0; ifc.in_instr = '0;
    idle_all();
    #1;
    // Reset state while rst_n is low.
    chk("rst_ov_a", 64'(ifa.out_valid), 64'd0);
    chk("rst_imm_a", {32'h0, ifa.out_imm}, 64'd0);
    chk("rst_type_a", 64'(ifa.out_type), 64'd0);
    chk("rst_ov_b", 64'(ifb.out_valid), 64'd0);
    chk("rst_imm_b", ifb.out_imm, 64'd0);
    chk("rst_ov_c", 64'(ifc.out_valid), 64'd0);
`ifdef IMMGEN_ILLEGAL_EN
    chk("rst_ill_a", 64'(ifa.out_illegal), 64'd0);
`endif
    rise();
    rise();
    rst_n = 1'b1;
    rise();
    chk("rdy_a", 64'(ifa.in_ready), 64'd1);
    chk("rdy_b", 64'(ifb.in_ready), 64'd1);
    chk("rdy_c", 64'(ifc.in_ready), 64'd1);

    // addi x0,x0,5 through A, one cycle latency.
    ifa.in_valid = 1'b1; ifa.in_instr = 32'h00500013;
    half();
    rise();
    ifa.in_valid = 1'b0;
    half();
    chk("t1_ov", 64'(ifa.out_valid), 64'd1);
    chk("t1_imm", {32'h0, ifa.out_imm}, 64'h5);
    chk("t1_type", 64'(ifa.out_type), 64'd1);
    rise();

    // Back-to-back S/B/U/J through A.
    t2_w   = '{32'h0020AA23, 32'hFE208EE3, 32'h123450B7, 32'h001000EF};
    t2_imm = '{32'h00000014, 32'hFFFFFFFC, 32'h12345000, 32'h00000800};
    t2_typ = '{3'd2, 3'd3, 3'd4, 3'd5};
    for (int i = 0; i < 5; i++) begin
      ifa.in_valid = (i < 4);
      ifa.in_instr = (i < 4) ? t2_w[i] : 32'h0;
      half();
      if (i > 0) begin
        chk($sformatf("t2_ov_%0d", i), 64'(ifa.out_valid), 64'd1);
        chk($sformatf("t2_imm_%0d", i), {32'h0, ifa.out_imm}, {32'h0, t2_imm[i-1]});
        chk($sformatf("t2_type_%0d", i), 64'(ifa.out_type), 64'(t2_typ[i-1]));
      end
      rise();
    end
    ifa.in_valid = 1'b0;

    // Stream 6 words into B with the consumer stalled during cycles 3..6.
    t3_w = '{32'h00100013, 32'hFFF00013, 32'h800000B7, 32'h0020AA23, 32'hFE208EE3, 32'h001000EF};
    begin
      int j;
      j = 0;
      for (int n = 0; n < 16; n++) begin
        ifb.out_ready = !(n >= 3 && n <= 6);
        ifb.in_valid  = (j < 6);
        ifb.in_instr  = (j < 6) ? t3_w[j] : 32'h0;
        half();
        if (n == 4) begin
          chk("t3_full_rdy", 64'(ifb.in_ready), 64'd0);
          chk("t3_full_ov", 64'(ifb.out_valid), 64'd1);
        end
        if (ifb.in_valid && ifb.in_ready) j++;
        rise();
      end
      chk("t3_all_in", 64'(j), 64'd6);
    end
    drain("t3");

    // 64-bit sign extension of I and U immediates through B.
    ifb.in_valid = 1'b1; ifb.in_instr = 32'hFFF00013;
    half(); rise();
    ifb.in_instr = 32'h800000B7;
    half(); rise();
    ifb.in_valid = 1'b0;
    half();
    chk("t5_imm_i", ifb.out_imm, 64'hFFFFFFFFFFFFFFFF);
    chk("t5_type_i", 64'(ifb.out_type), 64'd1);
    rise();
    half();
    chk("t5_imm_u", ifb.out_imm, 64'hFFFFFFFF80000000);
    chk("t5_type_u", 64'(ifb.out_type), 64'd4);
    rise();

    // Encodings without an immediate through A.
    ifa.in_valid = 1'b1; ifa.in_instr = 32'h00000000;
    half(); rise();
    ifa.in_instr = 32'h00000033;
    half();
    chk("t6_imm0", {32'h0, ifa.out_imm}, 64'd0);
    chk("t6_type0", 64'(ifa.out_type), 64'd0);
`ifdef IMMGEN_ILLEGAL_EN
    chk("t6_ill0", 64'(ifa.out_illegal), 64'd1);
`endif
    rise();
    ifa.in_valid = 1'b0;
    half();
    chk("t6_type1", 64'(ifa.out_type), 64'd0);
`ifdef IMMGEN_ILLEGAL_EN
    chk("t6_ill1", 64'(ifa.out_illegal), 64'd0);
`endif
    rise();
    drain("t6");

    // Random traffic with random backpressure on all three.
    for (int n = 0; n < 300; n++) begin
      ifa.in_valid = ($urandom_range(0, 3) != 0); ifa.in_instr = rand_word();
      ifb.in_valid = ($urandom_range(0, 3) != 0); ifb.in_instr = rand_word();
      ifc.in_valid = ($urandom_range(0, 3) != 0); ifc.in_instr = rand_word();
      ifa.out_ready = ($urandom_range(0, 2) != 0);
      ifb.out_ready = ($urandom_range(0, 2) != 0);
      ifc.out_ready = ($urandom_range(0, 2) != 0);
      half();
      rise();
    end
    drain("rnd");

    // Asynchronous reset mid-cycle while C holds three items.
    ifc.out_ready = 1'b0;
    ifc.in_valid  = 1'b1;
    for (int i = 0; i < 3; i++) begin
      ifc.in_instr = 32'hFFF00013;
      half();
      rise();
    end
    ifc.in_valid = 1'b0;
    half();
    chk("t4_pre_ov", 64'(ifc.out_valid), 64'd1);
    chk("t4_pre_rdy", 64'(ifc.in_ready), 64'd0);
    #2;
    rst_n = 1'b0;
    #1;
    chk("t4_ov", 64'(ifc.out_valid), 64'd0);
    chk("t4_imm", {32'h0, ifc.out_imm}, 64'd0);
    chk("t4_type", 64'(ifc.out_type), 64'd0);
    for (int d = 0; d < 3; d++) begin
      q[d].delete();
      held[d] = 1'b0;
    end
    rise();
    rst_n = 1'b1;
    ifc.out_ready = 1'b1;
    rise();
    chk("t4_rdy", 64'(ifc.in_ready), 64'd1);
    half();
    chk("t4_post_ov", 64'(ifc.out_valid), 64'd0);
    rise();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
